ctr_decryptor: RTL
==================

# ctr_decryptor

Streaming AES-256-CTR decryptor: the receive-side counterpart of the `encryptedctr` encryption path. It accepts ciphertext as a stream of 128-bit blocks and generates counter blocks from a latched IV. It drives an external AES-256 block core through a request/response interface and XORs the returned keystream onto the ciphertext to emit plaintext blocks. It sits between the link/receive buffer and the consumer of recovered plaintext; the AES core is shared and instantiated outside.

## Interface
Parameters:
- `KS_DEPTH`, default 4: keystream FIFO depth in blocks, power of two, 2..16. Also bounds the number of outstanding AES requests.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse in IDLE; latches `key` and `iv` and begins a message.
- `key` in 256: AES-256 key, sampled on `start`.
- `iv` in 128: initial counter block, sampled on `start`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a message has fully completed.
- `ct_valid` / `ct_ready` in / out 1: ciphertext handshake.
- `ct_data` in 128: ciphertext block.
- `ct_last` in 1: marks the final block.
- `pt_valid` / `pt_ready` out / in 1: plaintext handshake.
- `pt_data` out 128: plaintext block.
- `pt_last` out 1: final-block marker.
- `aes_req_valid` / `aes_req_ready` out / in 1: AES request handshake.
- `aes_req_block` out 128: counter block to encrypt.
- `aes_key` out 256: latched key, stable while `busy`.
- `aes_resp_valid` in 1: AES result strobe; this path has no backpressure.
- `aes_resp_data` in 128: keystream block.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start` latches `key`, sets `ctr <= iv`, clears the FIFO and outstanding count, then moves to RUN.
  - `start` outside IDLE is ignored.
- **Request issue (RUN only)**
  - `aes_req_valid = (outstanding + fifo_count) < KS_DEPTH`.
  - `aes_req_block = ctr`.
  - On an `aes_req_valid && aes_req_ready` handshake: `ctr` increments and `outstanding` increments.
  - Each `aes_resp_valid` pushes into the FIFO and decrements `outstanding`. The credit check guarantees the FIFO never overflows.
  - A request handshake and a response in the same cycle leave `outstanding` unchanged.
- **Counter arithmetic**: 128-bit increment with wrap mod 2^128, so `ffff…ff` becomes `0000…00`.
- **Data path**
  - `ct_ready = (state==RUN) && fifo_not_empty && (!pt_valid || pt_ready)`.
  - On a ct handshake: `pt_data <= ct_data ^ fifo_head`, `pt_last <= ct_last`, `pt_valid <= 1`, and the FIFO pops.
  - `pt_valid` clears on a `pt_ready` handshake unless a new ct handshake occurs in the same cycle.
- **Leaving RUN**
  - Taken on the ct handshake with `ct_last`: go to DRAIN.
  - Request issue stops; prefetched keystream is surplus.
- **DRAIN**
  - Discard the FIFO contents and any returning responses until `outstanding==0` and the final `pt` handshake has completed.
  - Then move to DONE.
- **DONE**: `done=1` for one cycle, then IDLE. `aes_key` and `ctr` hold their values.
- **Reset mid-message**: abandons all state immediately. Responses arriving after reset deasserts while in IDLE are ignored.

## Timing
- Reset values:
  - `busy`, `done`, `ct_ready`, `pt_valid`, `pt_last`, `aes_req_valid` = 0.
  - `pt_data`, `aes_req_block`, `aes_key` = 0.
  - State = IDLE.
- The first `aes_req_valid` is asserted the cycle after `start`.
- ct → pt latency is 1 cycle (registered) when the keystream is available.
- Sustained throughput is 1 block/cycle, provided the AES core returns at least one response per cycle and `KS_DEPTH` covers its latency.
- `done` is asserted exactly 1 cycle after DRAIN exits.

## Configuration
- `CTR_DECRYPTOR_CNT32_EN`:
  - **Defined**: only `ctr[31:0]` increments, wrapping mod 2^32; `ctr[127:32]` stays fixed at `iv[127:32]`.
  - **Undefined**: full 128-bit increment.

## Structure
- Package `aes_ctr_pkg`:
  - `block_t` (`logic [127:0]`) and `key_t` (`logic [255:0]`).
  - The FSM state enum.
  - Function `ctr_inc(block_t)`, with the macro-selected width.
- One sub-module, `ks_fifo`: parameterised synchronous FIFO of `block_t`, with count, push, pop and flush.

## Test plan
- **Single block**
  - Stimulus: key `1f1e…0100`, iv `ffeeddccbbaa99887766554433221100`, bench AES model, one ct block with `ct_last`.
  - Response: one `aes_req_block` equals the iv; `pt` = ct ^ AES(iv); `pt_last=1`; `done` pulses once.
- **Round trip**
  - Stimulus: feed the `encryptedctr` output for the 1024-bit plaintext `D22DB070…F1D806` as 8 blocks.
  - Response: `pt` reproduces the plaintext exactly; counters are iv … iv+7.
- **Backpressure**
  - Stimulus: AES latency 5 cycles, `KS_DEPTH=4`, `pt_ready` toggling every other cycle.
  - Response: outstanding + buffered never exceeds 4; no block is lost or duplicated.
- **Counter wrap**
  - Stimulus: iv `ffff…fffe`, 3 blocks.
  - Response: requests are `…fffe`, `…ffff`, `0000…0000`.
  - With `CTR_DECRYPTOR_CNT32_EN` and iv `0123…89abfffffffe`: the third request is `0123…89ab00000000`.
- **Drain**
  - Stimulus: `ct_last` on the first block while 3 requests are outstanding.
  - Response: `done` only after all 3 responses return; a new `start` then works from a clean state.
- **Reset mid-message**
  - Stimulus: `rst` low during RUN with `pt_valid=1`.
  - Response: all outputs reach their reset values asynchronously; a later `start` decrypts correctly.

Source files
------------

// File: rtl/ctr_decryptor_pkg.sv
// Shared types, FSM encoding and counter increment for the AES-256-CTR decrypt path.
// CTR_DECRYPTOR_CNT32_EN: when defined only ctr[31:0] increments, upper 96 bits hold.
package aes_ctr_pkg;

  typedef logic [127:0] block_t;
  typedef logic [255:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic block_t ctr_inc(input block_t c);
    block_t r;
    r = c;
`ifdef CTR_DECRYPTOR_CNT32_EN
    r[31:0] = c[31:0] + 32'd1;
`else
    r = c + 128'd1;
`endif
    return r;
  endfunction

endpackage

// File: rtl/ctr_decryptor_ks_fifo.sv
// Keystream FIFO of block_t with synchronous flush; head visible combinationally.
// Zero-latency head; no backpressure of its own, caller never pushes when full or pops when empty.
module ks_fifo
  import aes_ctr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  block_t        i_push_dat,
  input  logic          i_pop,
  output block_t        o_head_dat,
  output logic [CW-1:0] o_count,
  output logic          o_empty
);

  block_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/ctr_decryptor.sv
// Streaming AES-256-CTR decryptor: pt = ct ^ AES(ctr), 1-cycle registered ct->pt, stalls ct when keystream is empty or pt is held.
// AES requests are credit-limited to KS_DEPTH; CTR_DECRYPTOR_CNT32_EN selects a 32-bit counter field.
module ctr_decryptor
  import aes_ctr_pkg::*;
#(
  parameter int KS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [127:0] iv,
  output logic         busy,
  output logic         done,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [127:0] ct_data,
  input  logic         ct_last,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [127:0] pt_data,
  output logic         pt_last,
  output logic         aes_req_valid,
  input  logic         aes_req_ready,
  output logic [127:0] aes_req_block,
  output logic [255:0] aes_key,
  input  logic         aes_resp_valid,
  input  logic [127:0] aes_resp_data
);

  localparam int CW = $clog2(KS_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(KS_DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  key_t          r_key;
  block_t        r_ctr;
  logic [CW-1:0] r_outstanding;
  logic          r_pt_valid;
  logic          r_pt_last;
  block_t        r_pt_data;

  block_t        w_ks_head;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_empty;
  logic [CW:0]   w_credit_used;
  logic          w_start;
  logic          w_req_hs;
  logic          w_ct_hs;
  logic          w_pt_hs;
  logic          w_resp_live;
  logic          w_fifo_push;
  logic          w_fifo_flush;

  assign w_start       = (r_state == ST_IDLE) && start;
  assign w_req_hs      = aes_req_valid && aes_req_ready;
  assign w_ct_hs       = ct_valid && ct_ready;
  assign w_pt_hs       = r_pt_valid && pt_ready;
  // Stray responses seen in IDLE/DONE (e.g. after a mid-message reset) must not touch the credit count.
  assign w_resp_live   = aes_resp_valid && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_fifo_push   = aes_resp_valid && (r_state == ST_RUN);
  assign w_fifo_flush  = w_start || (r_state == ST_DRAIN);
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};

  ks_fifo #(.DEPTH(KS_DEPTH)) u_ks_fifo (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_flush    (w_fifo_flush),
    .i_push     (w_fifo_push),
    .i_push_dat (aes_resp_data),
    .i_pop      (w_ct_hs),
    .o_head_dat (w_ks_head),
    .o_count    (w_fifo_count),
    .o_empty    (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_ct_hs && ct_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if ((r_outstanding == '0) && !r_pt_valid) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (r_state != ST_IDLE);
    done          = (r_state == ST_DONE);
    aes_req_valid = (r_state == ST_RUN) && (w_credit_used < DEPTH_L);
    ct_ready      = (r_state == ST_RUN) && !w_fifo_empty && (!r_pt_valid || pt_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key <= '0;
      r_ctr <= '0;
    end else if (w_start) begin
      r_key <= key;
      r_ctr <= iv;
    end else if (w_req_hs) begin
      r_ctr <= ctr_inc(r_ctr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outstanding <= '0;
    end else if (w_start) begin
      r_outstanding <= '0;
    end else begin
      case ({w_req_hs, w_resp_live})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pt_valid <= 1'b0;
      r_pt_last  <= 1'b0;
      r_pt_data  <= '0;
    end else if (w_ct_hs) begin
      r_pt_valid <= 1'b1;
      r_pt_last  <= ct_last;
      r_pt_data  <= ct_data ^ w_ks_head;
    end else if (w_pt_hs) begin
      r_pt_valid <= 1'b0;
    end
  end

  assign pt_valid      = r_pt_valid;
  assign pt_last       = r_pt_last;
  assign pt_data       = r_pt_data;
  assign aes_req_block = r_ctr;
  assign aes_key       = r_key;

endmodule
